// File: rtl/slot_alloc_decoder.sv
// rtl/slot_alloc_decoder.sv - lowest-free-entry allocator with one-hot write enables
// Grants the lowest-indexed free entry combinationally; busy/count update on the rising edge.
module slot_alloc_decoder #(
  parameter  int NUM_SLOTS = 8,
  localparam int ADDR_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_req,
  output logic                 alloc_grant,
  output logic [ADDR_W-1:0]    alloc_addr,
  output logic [NUM_SLOTS-1:0] alloc_onehot,
  input  logic                 free_en,
  input  logic [ADDR_W-1:0]    free_addr,
  input  logic                 flush,
  output logic [NUM_SLOTS-1:0] busy,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 empty,
  output logic                 free_err
);

  localparam logic [ADDR_W:0]      FULL_COUNT = (ADDR_W+1)'(NUM_SLOTS);
  localparam logic [NUM_SLOTS-1:0] ONE_BIT    = NUM_SLOTS'(1);

  logic [NUM_SLOTS-1:0] free_mask;
  logic                 free_valid;
  logic                 free_bad;
  logic [ADDR_W:0]      count_next;
  logic [NUM_SLOTS-1:0] busy_next;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Scan downward so the lowest free index is the last one written; defaults to 0 when full.
  always_comb begin
    alloc_addr = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_addr = ADDR_W'(i);
      end
    end
  end

  assign alloc_grant  = alloc_req & ~full & ~reset & ~flush;
  assign alloc_onehot = alloc_grant ? (ONE_BIT << alloc_addr) : '0;

  assign free_mask  = free_en ? (ONE_BIT << free_addr) : '0;
  assign free_valid = free_en & busy[free_addr];
  assign free_bad   = free_en & ~busy[free_addr];

  // A freed slot stays unavailable to the allocator until the following cycle.
  assign busy_next = (busy & ~free_mask) | alloc_onehot;

  always_comb begin
    count_next = count;
    case ({alloc_grant, free_valid})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy     <= '0;
      count    <= '0;
      free_err <= 1'b0;
    end else begin
      busy     <= busy_next;
      count    <= count_next;
      free_err <= free_bad;
    end
  end

endmodule
